// File: rtl/module_spi_slave.sv
// Mode-0 SPI responder: oversamples SCLK/CS/MOSI, shifts W-bit words in and out,
// with a one-entry TX holding buffer and a one-cycle RX strobe.
module module_spi_slave #(
   parameter int             W      = 8,
   parameter int             CNT_W  = 10,
   parameter logic [W-1:0]   DEF_TX = '1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sclk_i,
   input  logic             cs_i,
   input  logic             mosi_i,
   output logic             miso_o,
   input  logic [W-1:0]     tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [W-1:0]     rx_data_o,
   output logic             rx_valid_o,
   output logic [CNT_W-1:0] n_rx_o,
   output logic             busy_o,
   output logic             underrun_o
);

   localparam int BC_W = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } state_t;

   state_t          state;
   logic            sclk_s1, sclk_s2, sclk_d;
   logic            cs_s1, cs_s2;
   logic            mosi_s1, mosi_s2;
   logic            sclk_rise_q, sclk_fall_q;
   logic [BC_W-1:0] bit_cnt;
   logic [W-2:0]    rx_shift;
   logic [W-1:0]    rx_next;
   logic [W-1:0]    tx_shift;
   logic [W-1:0]    buf_data;
   logic            buf_full;
   logic            load_now;
   logic [W-1:0]    next_word;

   // Edge pulses are registered so the FSM sees a clean one-cycle strobe per SCLK edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sclk_s1     <= 1'b0;
         sclk_s2     <= 1'b0;
         sclk_d      <= 1'b0;
         cs_s1       <= 1'b1;
         cs_s2       <= 1'b1;
         mosi_s1     <= 1'b0;
         mosi_s2     <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
      end else begin
         sclk_s1     <= sclk_i;
         sclk_s2     <= sclk_s1;
         sclk_d      <= sclk_s2;
         cs_s1       <= cs_i;
         cs_s2       <= cs_s1;
         mosi_s1     <= mosi_i;
         mosi_s2     <= mosi_s1;
         sclk_rise_q <= sclk_s2 & ~sclk_d;
         sclk_fall_q <= ~sclk_s2 & sclk_d;
      end
   end

   always_comb begin
      load_now = 1'b0;
      if (!cs_s2) begin
         load_now = (state == LOAD) ||
                    ((state == SHIFT) && sclk_fall_q && (bit_cnt == '0));
      end
      if (buf_full)
         next_word = buf_data;
      else if (tx_valid_i)
         next_word = tx_data_i;
      else
         next_word = DEF_TX;
      rx_next = {rx_shift, mosi_s2};
   end

   assign tx_ready_o = ~buf_full;
   assign busy_o     = (state != IDLE);
   assign miso_o     = tx_shift[W-1];

   // Buffer writes are refused only while full, so a write colliding with a buffer
   // load stalls naturally; an empty buffer with a same-cycle write is the bypass case.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         buf_data   <= '0;
         buf_full   <= 1'b0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         n_rx_o     <= '0;
         underrun_o <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;
         underrun_o <= 1'b0;

         if (load_now) begin
            if (buf_full)
               buf_full <= 1'b0;
            else if (!tx_valid_i)
               underrun_o <= 1'b1;
         end else if (tx_valid_i && !buf_full) begin
            buf_data <= tx_data_i;
            buf_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               tx_shift <= '0;
               if (!cs_s2)
                  state <= LOAD;
            end
            LOAD: begin
               if (cs_s2) begin
                  state    <= IDLE;
                  tx_shift <= '0;
               end else begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  n_rx_o   <= '0;
                  tx_shift <= next_word;
               end
            end
            SHIFT: begin
               if (cs_s2) begin
                  state    <= IDLE;
                  tx_shift <= '0;
               end else if (sclk_rise_q) begin
                  rx_shift <= rx_next[W-2:0];
                  if (bit_cnt == BC_W'(W - 1)) begin
                     rx_data_o  <= rx_next;
                     rx_valid_o <= 1'b1;
                     n_rx_o     <= n_rx_o + CNT_W'(1);
                     bit_cnt    <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + BC_W'(1);
                  end
               end else if (sclk_fall_q) begin
                  if (bit_cnt != '0)
                     tx_shift <= {tx_shift[W-2:0], 1'b0};
                  else
                     tx_shift <= next_word;
               end
            end
            default: begin
               state    <= IDLE;
               tx_shift <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_spi_slave.sv
// Bench for module_spi_slave: a mode-0 master model at 100 kHz on a 10 MHz clk_i,
// a table of single-word frames and hand-written multi-word, abort and reset sequences.
module tb_module_spi_slave;

   localparam int W     = 8;
   localparam int CNT_W = 10;
   localparam int HALF  = 50;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             sclk_i = 1'b0;
   logic             cs_i = 1'b1;
   logic             mosi_i = 1'b0;
   logic             miso_o;
   logic [W-1:0]     tx_data_i = '0;
   logic             tx_valid_i = 1'b0;
   logic             tx_ready_o;
   logic [W-1:0]     rx_data_o;
   logic             rx_valid_o;
   logic [CNT_W-1:0] n_rx_o;
   logic             busy_o;
   logic             underrun_o;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc = 0;
   int rx_pulses = 0;
   int ur_pulses = 0;
   int valid_cyc = 0;
   int last_rise_cyc = 0;

   typedef struct {
      logic       preload;
      logic [7:0] tx_word;
      logic [7:0] mosi_word;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
      int         exp_underruns;
   } vec_t;

   vec_t vecs[4];

   module_spi_slave #(.W(W), .CNT_W(CNT_W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sclk_i     (sclk_i),
      .cs_i       (cs_i),
      .mosi_i     (mosi_i),
      .miso_o     (miso_o),
      .tx_data_i  (tx_data_i),
      .tx_valid_i (tx_valid_i),
      .tx_ready_o (tx_ready_o),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .n_rx_o     (n_rx_o),
      .busy_o     (busy_o),
      .underrun_o (underrun_o)
   );

   always #50 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Pulse counters sampled on the falling edge, away from the DUT's active edge.
   always @(negedge clk_i) begin
      if (rx_valid_o) begin
         rx_pulses = rx_pulses + 1;
         valid_cyc = cyc;
      end
      if (underrun_o)
         ur_pulses = ur_pulses + 1;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic half_period();
      repeat (HALF) @(posedge clk_i);
      #1;
   endtask

   task automatic write_tx(input logic [7:0] w);
      tx_data_i  = w;
      tx_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      tx_valid_i = 1'b0;
   endtask

   task automatic frame_start();
      cs_i = 1'b0;
      half_period();
   endtask

   task automatic frame_end();
      sclk_i = 1'b0;
      half_period();
      cs_i = 1'b1;
      half_period();
   endtask

   task automatic spi_bit(input logic b, output logic m);
      sclk_i = 1'b0;
      mosi_i = b;
      half_period();
      m = miso_o;
      sclk_i = 1'b1;
      last_rise_cyc = cyc;
      half_period();
   endtask

   task automatic xfer_word(input logic [7:0] mw, output logic [7:0] sw);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(mw[i], m);
         sw[i] = m;
      end
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      logic [7:0] got;
      int rx0, ur0;
      if (v.preload)
         write_tx(v.tx_word);
      rx0 = rx_pulses;
      ur0 = ur_pulses;
      frame_start();
      xfer_word(v.mosi_word, got);
      check_output($sformatf("vec%0d rx_data", idx), 32'(rx_data_o), 32'(v.exp_rx));
      check_output($sformatf("vec%0d miso_word", idx), 32'(got), 32'(v.exp_miso));
      check_output($sformatf("vec%0d rx_pulses", idx), 32'(rx_pulses - rx0), 32'd1);
      check_output($sformatf("vec%0d underruns", idx), 32'(ur_pulses - ur0), 32'(v.exp_underruns));
      check_output($sformatf("vec%0d n_rx", idx), 32'(n_rx_o), 32'd1);
      check_output($sformatf("vec%0d latency", idx), 32'(valid_cyc - last_rise_cyc), 32'd4);
      check_output($sformatf("vec%0d busy", idx), 32'(busy_o), 32'd1);
      frame_end();
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, " miso"},     32'(miso_o),     32'd0);
      check_output({tag, " tx_ready"}, 32'(tx_ready_o), 32'd1);
      check_output({tag, " rx_data"},  32'(rx_data_o),  32'd0);
      check_output({tag, " rx_valid"}, 32'(rx_valid_o), 32'd0);
      check_output({tag, " n_rx"},     32'(n_rx_o),     32'd0);
      check_output({tag, " busy"},     32'(busy_o),     32'd0);
      check_output({tag, " underrun"}, 32'(underrun_o), 32'd0);
   endtask

   initial begin
      logic [7:0] got1, got2;
      logic m;
      int rx0, ur0;

      vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0};
      vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 0};
      vecs[2] = '{1'b0, 8'h00, 8'h81, 8'h81, 8'hFF, 1};
      vecs[3] = '{1'b1, 8'h6E, 8'hC5, 8'hC5, 8'h6E, 0};

      rst_i = 1'b0;
      repeat (100) @(posedge clk_i);
      #1;
      check_reset_values("reset");
      rst_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      check_reset_values("post_reset");

      for (int i = 0; i < 4; i++)
         apply_stimulus(vecs[i], i);

      // Two words in one frame, second TX word written while the first is shifting.
      write_tx(8'hA5);
      rx0 = rx_pulses;
      frame_start();
      for (int i = 7; i >= 0; i--) begin
         spi_bit(1'(8'h11 >> i), m);
         got1[i] = m;
         if (i == 4) begin
            write_tx(8'h5A);
            check_output("b2b buffer_full", 32'(tx_ready_o), 32'd0);
         end
      end
      check_output("b2b rx_word1", 32'(rx_data_o), 32'h11);
      xfer_word(8'h22, got2);
      check_output("b2b miso_word1", 32'(got1), 32'hA5);
      check_output("b2b miso_word2", 32'(got2), 32'h5A);
      check_output("b2b rx_word2", 32'(rx_data_o), 32'h22);
      check_output("b2b n_rx", 32'(n_rx_o), 32'd2);
      check_output("b2b rx_pulses", 32'(rx_pulses - rx0), 32'd2);
      check_output("b2b tx_ready", 32'(tx_ready_o), 32'd1);
      frame_end();

      // Abort after three bits with a word parked in the buffer.
      write_tx(8'hC3);
      rx0 = rx_pulses;
      frame_start();
      write_tx(8'hD2);
      for (int i = 0; i < 3; i++)
         spi_bit(1'b1, m);
      frame_end();
      check_output("abort rx_pulses", 32'(rx_pulses - rx0), 32'd0);
      check_output("abort busy", 32'(busy_o), 32'd0);
      check_output("abort buffer_kept", 32'(tx_ready_o), 32'd0);
      check_output("abort rx_data_held", 32'(rx_data_o), 32'h22);
      check_output("abort n_rx", 32'(n_rx_o), 32'd0);
      check_output("abort miso_idle", 32'(miso_o), 32'd0);
      rx0 = rx_pulses;
      ur0 = ur_pulses;
      frame_start();
      xfer_word(8'h96, got1);
      check_output("after_abort miso_word", 32'(got1), 32'hD2);
      check_output("after_abort rx_data", 32'(rx_data_o), 32'h96);
      check_output("after_abort n_rx", 32'(n_rx_o), 32'd1);
      check_output("after_abort rx_pulses", 32'(rx_pulses - rx0), 32'd1);
      check_output("after_abort underruns", 32'(ur_pulses - ur0), 32'd0);
      frame_end();

      // Reset asserted partway through a frame.
      write_tx(8'h4B);
      frame_start();
      for (int i = 0; i < 5; i++)
         spi_bit(1'b1, m);
      rst_i = 1'b0;
      #1;
      check_reset_values("mid_reset");
      cs_i   = 1'b1;
      sclk_i = 1'b0;
      mosi_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      write_tx(8'h69);
      rx0 = rx_pulses;
      frame_start();
      xfer_word(8'hE7, got1);
      check_output("post_mid_reset miso_word", 32'(got1), 32'h69);
      check_output("post_mid_reset rx_data", 32'(rx_data_o), 32'hE7);
      check_output("post_mid_reset n_rx", 32'(n_rx_o), 32'd1);
      check_output("post_mid_reset rx_pulses", 32'(rx_pulses - rx0), 32'd1);
      frame_end();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
